// File: rtl/subbytes_sequencer.sv
// -----------------------------------------------------------------------------
// subbytes_sequencer
//
// Runs AES SubBytes on a 128-bit state by streaming its 16 bytes, one per
// cycle, through a single shared S-box and collecting the substituted bytes
// back into the result register in the same order.
//
// Parameters
//   SBOX_LAT   latency of the external S-box: 0 = combinational, 1 = registered
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      job request, sampled only while idle
//   state_in   input state, byte k = state_in[127-8k -: 8]
//   sbox_out   substituted byte returned by the shared S-box
//   sbox_in    byte presented to the shared S-box (0 when not issuing)
//   sbox_en    high while sbox_in carries a valid issue byte
//   state_out  SubBytes result, same byte ordering as state_in
//   busy       high while a job is running
//   done       one-cycle pulse when state_out holds the new result
// -----------------------------------------------------------------------------
module subbytes_sequencer #(
   parameter int SBOX_LAT = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] state_in,
   input  logic [7:0]   sbox_out,
   output logic [7:0]   sbox_in,
   output logic         sbox_en,
   output logic [127:0] state_out,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [4:0]     issue_cnt;
   logic [4:0]     wb_cnt;
   logic [127:0]   shadow;
   logic [127:0]   result;
   logic [127:0]   shadow_shift;
   logic           accept;
   logic           issue_active;
   logic           issue_vld_p1;
   logic           wb_fire;

   assign accept       = (state_q == IDLE) && start;
   assign issue_active = (state_q == RUN) && (issue_cnt < 5'd16);

   // Byte i sits at the top of the shadow once shifted left by 8*i bits.
   assign shadow_shift = shadow << {issue_cnt[3:0], 3'b000};

   // With a registered S-box the returned byte belongs to the previous
   // cycle's issue, so writeback follows the delayed issue valid.
   assign wb_fire = (state_q == RUN) && (wb_cnt < 5'd16) &&
                    ((SBOX_LAT == 0) ? issue_active : issue_vld_p1);

   // ---- next-state logic ----------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN:  if (wb_fire && (wb_cnt == 5'd15)) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---- state, counters, shadow and result registers ------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         issue_cnt    <= 5'd0;
         wb_cnt       <= 5'd0;
         shadow       <= 128'd0;
         result       <= 128'd0;
         issue_vld_p1 <= 1'b0;
      end else begin
         state_q      <= state_d;
         issue_vld_p1 <= issue_active;
         if (accept) begin
            shadow    <= state_in;
            issue_cnt <= 5'd0;
            wb_cnt    <= 5'd0;
         end else begin
            if (issue_active) issue_cnt <= issue_cnt + 5'd1;
            if (wb_fire) begin
               wb_cnt <= wb_cnt + 5'd1;
               for (int k = 0; k < 16; k++) begin
                  if (wb_cnt[3:0] == k[3:0]) result[127-8*k -: 8] <= sbox_out;
               end
            end
         end
      end
   end

   // ---- outputs ---------------------------------------------------------------
   assign sbox_en   = issue_active;
   assign sbox_in   = issue_active ? shadow_shift[127:120] : 8'h00;
   assign state_out = result;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_subbytes_sequencer.sv
// -----------------------------------------------------------------------------
// tb_subbytes_sequencer
//
// Two sequencer instances (SBOX_LAT = 0 and 1) are exercised one after the
// other. Each has its own S-box model (computed from GF(2^8) inversion plus
// the affine map) and a scoreboard of expected results and done cycles.
// -----------------------------------------------------------------------------
module tb_subbytes_sequencer;

   localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

   logic                clk;
   logic                rst_n;
   logic [1:0]          start_v;
   logic [1:0][127:0]   sti_v;
   wire  [1:0][7:0]     sin_v;
   wire  [1:0]          en_v;
   wire  [1:0][127:0]   sout_v;
   wire  [1:0]          busy_v;
   wire  [1:0]          done_v;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_f(input logic [7:0] x);
      logic [7:0] r, base, s;
      r = 8'h01; base = x;
      // x^254 is the multiplicative inverse (0 maps to 0)
      for (int e = 254; e > 0; e = e >> 1) begin
         if (e[0]) r = gmul(r, base);
         base = gmul(base, base);
      end
      s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
      return s;
   endfunction

   function automatic logic [127:0] subbytes(input logic [127:0] st);
      logic [127:0] o;
      for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox_f(st[127-8*k -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   typedef struct packed {
      logic [127:0] res;
      int           at;
   } exp_t;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int L = g;
      logic [7:0] sbox_out_l;

      if (g == 0) begin : g_comb
         assign sbox_out_l = sbox_f(sin_v[g]);
      end else begin : g_reg
         always @(posedge clk) sbox_out_l <= sbox_f(sin_v[g]);
      end

      subbytes_sequencer #(.SBOX_LAT(g)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .start     (start_v[g]),
         .state_in  (sti_v[g]),
         .sbox_out  (sbox_out_l),
         .sbox_in   (sin_v[g]),
         .sbox_en   (en_v[g]),
         .state_out (sout_v[g]),
         .busy      (busy_v[g]),
         .done      (done_v[g])
      );

      exp_t         q[$];
      int           busy_until = 0;
      int           job_e0     = 0;
      int           ndone      = 0;
      logic         job_valid  = 1'b0;
      logic [127:0] job_state  = '0;
      logic [127:0] last_res   = '0;

      always @(negedge clk) begin
         int           rel;
         logic         exp_en;
         logic         exp_busy;
         logic [127:0] tmp;
         exp_t         e;
         if (!rst_n) begin
            q.delete();
            busy_until = 0;
            job_valid  = 1'b0;
            last_res   = '0;
            chk("rst_en",   128'(en_v[g]),   128'(0));
            chk("rst_busy", 128'(busy_v[g]), 128'(0));
            chk("rst_done", 128'(done_v[g]), 128'(0));
            chk("rst_out",  sout_v[g],       128'(0));
         end else begin
            rel      = cyc - job_e0;
            exp_en   = job_valid && (rel >= 0) && (rel < 16);
            exp_busy = job_valid && (rel >= 0) && (rel < 16 + L);
            tmp      = exp_en ? (job_state << (8 * rel)) : 128'd0;
            chk("sbox_en",  128'(en_v[g]),   128'(exp_en));
            chk("sbox_in",  128'(sin_v[g]),  128'(tmp[127:120]));
            chk("busy",     128'(busy_v[g]), 128'(exp_busy));
            if (done_v[g]) begin
               ndone++;
               if (q.size() == 0) begin
                  chk("spurious_done", 128'(1), 128'(0));
               end else begin
                  e = q.pop_front();
                  chk("done_cycle", 128'(cyc), 128'(e.at));
                  chk("result",     sout_v[g], e.res);
                  last_res = e.res;
               end
            end else if ((q.size() > 0) && (cyc > q[0].at)) begin
               chk("missed_done", 128'(0), 128'(1));
               void'(q.pop_front());
            end
            if ((cyc >= busy_until) && (q.size() == 0))
               chk("hold", sout_v[g], last_res);
            if ((cyc >= busy_until) && start_v[g]) begin
               job_e0     = cyc + 1;
               job_state  = sti_v[g];
               job_valid  = 1'b1;
               busy_until = cyc + 1 + 17 + L;
               e.res      = subbytes(sti_v[g]);
               e.at       = cyc + 1 + 16 + L;
               q.push_back(e);
            end
         end
      end
   end

   // Called just after an active edge; the following edge is the start edge.
   task automatic start_job(input int s, input logic [127:0] data);
      start_v[s] = 1'b1;
      sti_v[s]   = data;
      @(posedge clk); #1;
      start_v[s] = 1'b0;
      sti_v[s]   = rnd128();
   endtask

   task automatic chk_zero_outputs(input int s);
      chk("async_rst_en",   128'(en_v[s]),   128'(0));
      chk("async_rst_in",   128'(sin_v[s]),  128'(0));
      chk("async_rst_busy", 128'(busy_v[s]), 128'(0));
      chk("async_rst_done", 128'(done_v[s]), 128'(0));
      chk("async_rst_out",  sout_v[s],       128'(0));
   endtask

   initial begin
      logic [127:0] a_st, y_st;
      rst_n   = 1'b1;
      start_v = '0;
      sti_v   = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero_outputs(0);
      chk_zero_outputs(1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int s = 0; s < 2; s++) begin
         // FIPS vector, started on the first edge after reset release
         start_job(s, FIPS_IN);
         repeat (20) @(posedge clk); #1;
         chk("fips", sout_v[s], FIPS_OUT);

         // start pulses in RUN and in DONE with another state are ignored
         a_st = rnd128();
         start_job(s, a_st);
         repeat (5) @(posedge clk); #1;
         start_v[s] = 1'b1; sti_v[s] = rnd128();
         @(posedge clk); #1;
         start_v[s] = 1'b0;
         repeat (10 + s) @(posedge clk); #1;
         start_v[s] = 1'b1; sti_v[s] = rnd128();
         @(posedge clk); #1;
         start_v[s] = 1'b0;
         repeat (6) @(posedge clk); #1;
         chk("ignored_start", sout_v[s], subbytes(a_st));

         // reset while the issue counter is 7, then an all-zero job
         start_job(s, rnd128());
         repeat (7) @(posedge clk); #1;
         rst_n = 1'b0;
         #1;
         chk_zero_outputs(s);
         @(posedge clk);
         @(posedge clk); #1;
         rst_n = 1'b1;
         start_job(s, 128'd0);
         repeat (20) @(posedge clk); #1;
         chk("zero_state", sout_v[s], {16{8'h63}});

         // start held high across two jobs
         a_st = rnd128();
         y_st = rnd128();
         start_v[s] = 1'b1;
         sti_v[s]   = a_st;
         @(posedge clk); #1;
         sti_v[s] = y_st;
         repeat (18 + s) @(posedge clk); #1;
         start_v[s] = 1'b0;
         sti_v[s]   = rnd128();
         repeat (25) @(posedge clk); #1;
         chk("b2b_second", sout_v[s], subbytes(y_st));
      end

      repeat (3) @(posedge clk); #1;
      chk("done_count_lat0", 128'(g_dut[0].ndone), 128'(5));
      chk("done_count_lat1", 128'(g_dut[1].ndone), 128'(5));
      chk("pending_lat0", 128'(g_dut[0].q.size()), 128'(0));
      chk("pending_lat1", 128'(g_dut[1].q.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
